io_uart_tx: RTL and testbench

Core-side output peripheral at the far end of the core's status/result_bytes I/O interface.
- Accepts 1-4 byte write requests from the core.
- Buffers the bytes in a byte FIFO.
- Serializes them onto a UART TX line as 8N1, LSB first.
- Reports back-pressure and overflow so software and the bench can detect dropped output.

---
 rtl/io_pkg.sv | 14 +
 rtl/uart_tx.sv | 46 ++++
 rtl/io_uart_tx.sv | 75 +++++++
 tb/tb_io_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared status-word fields, serializer states and UART frame constants.
package io_pkg;
  localparam int STROBE_BIT = 0;
  localparam int CNT_LSB = 1;
  localparam int CNT_MSB = 2;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serializer with a valid/ready byte input, ready while idle.
module uart_tx
  import io_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);
  localparam int BW = $clog2(CLK_PER_BIT);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic baud_end, last_bit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
    end
  end
  always_comb begin
    baud_end = baud == BW'(CLK_PER_BIT - 1);
    last_bit = bit_cnt == 3'(DATA_BITS - 1);
    state_n = (state == IDLE) ? (valid ? START : IDLE) :
              !baud_end ? state :
              (state == START) ? DATA :
              (state == DATA) ? (last_bit ? STOP : DATA) : IDLE;
    baud_n = (state == IDLE || baud_end) ? '0 : baud + BW'(1);
    bit_n = (state == IDLE) ? '0 : (state == DATA && baud_end) ? bit_cnt + 3'd1 : bit_cnt;
    shift_n = (state == IDLE && valid) ? data : (state == DATA && baud_end) ? shift >> 1 : shift;
    ready = state == IDLE;
    txd = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
  end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: unpacks 1-4 byte core writes into a byte FIFO drained by a UART serializer.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] status,
  input  logic [31:0] result_bytes,
  output logic        txd,
  output logic        io_busy,
  output logic        overflow,
  output logic        tx_idle
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = FIFO_AW + 1;
  logic [31:0] stg_bytes;
  logic [2:0] stg_n;
  logic [1:0] stg_idx;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic strobe, occupied, full, empty, push, pop, tx_ready, unused_status;
  assign strobe = status[STROBE_BIT];
  assign unused_status = ^status[31:CNT_MSB+1];
  assign occupied = stg_n != 3'd0;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push = occupied && !full;
  assign pop = !empty && tx_ready;
  assign io_busy = occupied;
  assign tx_idle = !occupied && empty && tx_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_n <= '0;
      stg_idx <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (strobe & occupied);
      if (strobe && !occupied) begin
        stg_bytes <= result_bytes;
        stg_n <= {1'b0, status[CNT_MSB:CNT_LSB]} + 3'd1;
        stg_idx <= '0;
      end else if (push) begin
        stg_idx <= stg_idx + 2'd1;
        stg_n <= stg_n - 3'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) rptr <= rptr + FIFO_AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Payload memory needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= stg_bytes[{stg_idx, 3'b000} +: 8];
  end
  uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .data(mem[rptr]),
    .valid(!empty),
    .ready(tx_ready),
    .txd(txd)
  );
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed and random writes checked against an expected byte stream and a line decoder.
module tb_io_uart_tx;
  logic clk, rst;
  logic [31:0] status, result_bytes;
  logic txd, io_busy, overflow, tx_idle;
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int mpos = -1;
  logic [7:0] rb;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int starts[$];

  io_uart_tx #(.CLK_PER_BIT(4), .FIFO_AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .status(status),
    .result_bytes(result_bytes),
    .txd(txd),
    .io_busy(io_busy),
    .overflow(overflow),
    .tx_idle(tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line decoder: a frame begins at the first low sample, bits are sampled mid-cell.
  always @(negedge clk) begin
    if (rst) mpos = -1;
    else if (mpos < 0) begin
      if (txd === 1'b0) begin
        mpos = 0;
        starts.push_back(ncyc);
      end
    end else begin
      mpos++;
      if (mpos == 1) chk("start_bit", 32'(txd), 0);
      if (mpos >= 5 && mpos <= 33 && (mpos - 5) % 4 == 0) rb[(mpos - 5) / 4] = txd;
      if (mpos == 37) begin
        chk("stop_bit", 32'(txd), 1);
        rx_q.push_back(rb);
        mpos = -1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] cnt, input logic [31:0] data);
    status = {29'd0, cnt, 1'b1};
    result_bytes = data;
    for (int i = 0; i <= int'(cnt); i++) exp_q.push_back(data[8*i +: 8]);
    tick();
    status = 32'd0;
  endtask

  task automatic wait_free();
    int n = 0;
    while (io_busy && n < 2000) begin
      tick();
      n++;
    end
    chk("free_wait", 32'(io_busy), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(tx_idle && mpos < 0) && n < 5000);
    chk({tag, "_drain"}, 32'(tx_idle), 1);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
    starts.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int s;
    int lows;
    rst = 1'b1;
    status = 32'd0;
    result_bytes = 32'd0;
    tick();
    do_reset();
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(io_busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_idle", 32'(tx_idle), 1);

    strobe(2'd0, 32'h0000_0055);
    chk("single_busy", 32'(io_busy), 1);
    tick();
    chk("single_txd_t2", 32'(txd), 1);
    tick();
    chk("single_txd_t3", 32'(txd), 0);
    repeat (39) tick();
    chk("single_idle_stop", 32'(tx_idle), 0);
    tick();
    chk("single_idle_end", 32'(tx_idle), 1);
    drain("single");

    strobe(2'd3, 32'h4433_2211);
    for (int i = 1; i <= 4; i++) begin
      chk("four_busy", 32'(io_busy), 1);
      tick();
    end
    chk("four_busy_end", 32'(io_busy), 0);
    repeat (170) tick();
    chk("four_frames", starts.size(), 4);
    for (int i = 0; i + 1 < starts.size(); i++) chk("four_gap", starts[i+1] - starts[i], 41);
    drain("four");

    strobe(2'd3, 32'hDDCC_BBAA);
    status = 32'h1;
    result_bytes = 32'h0000_00AA;
    tick();
    status = 32'd0;
    chk("drop_ovf", 32'(overflow), 1);
    drain("drop");
    chk("drop_ovf_sticky", 32'(overflow), 1);
    do_reset();
    chk("drop_ovf_clr", 32'(overflow), 0);

    wait_free();
    strobe(2'd3, 32'h0403_0201);
    wait_free();
    strobe(2'd3, 32'h0807_0605);
    repeat (9) tick();
    chk("full_stall", 32'(io_busy), 1);
    wait_free();
    strobe(2'd3, 32'h0C0B_0A09);
    drain("full");
    chk("full_ovf", 32'(overflow), 0);

    status = 32'h3;
    result_bytes = 32'h0000_5A0F;
    tick();
    status = 32'd0;
    tick();
    tick();
    chk("rstmid_start", 32'(txd), 0);
    repeat (17) tick();
    chk("rstmid_bit3", 32'(txd), 1);
    rst = 1'b1;
    tick();
    chk("rstmid_txd", 32'(txd), 1);
    chk("rstmid_idle", 32'(tx_idle), 1);
    chk("rstmid_busy", 32'(io_busy), 0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    chk("rstmid_quiet", lows, 0);
    chk("rstmid_rx", rx_q.size(), 0);
    drain("rstmid");

    for (int i = 1; i <= 10; i++) begin
      wait_free();
      strobe(2'd0, 32'(i));
    end
    drain("wrap");

    for (int i = 0; i < 12; i++) begin
      wait_free();
      strobe(2'($urandom_range(0, 3)), $urandom);
      s = $urandom_range(0, 60);
      repeat (s) tick();
    end
    drain("rand");
    chk("rand_ovf", 32'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
